// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator execute unit and its ALU core:
// opcodes, flag bit positions and the control FSM encoding.
package alu_pkg;

   // ALU opcodes; bit 2 set marks the logic group (no carry/overflow)
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_PASS = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_NOT  = 3'd7;

   // Positions inside the {N, Z, C, V} flag vector
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // Control FSM encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu8_core.sv
// Purely combinational ALU: result, raw carry-out and raw signed overflow.
// Flag masking and zero chaining are left to the instantiating unit.
module alu8_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             cin,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0] sum_s;

   // Opcode decode: arithmetic through a WIDTH+1 bit adder, logic ops bitwise
   always_comb begin
      sum_s = '0;
      y     = '0;
      cout  = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            y     = sum_s[WIDTH-1:0];
            cout  = sum_s[WIDTH];
            ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // Two's-complement subtract; carry-out is the no-borrow indicator
            sum_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
            y     = sum_s[WIDTH-1:0];
            cout  = sum_s[WIDTH];
            ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_INC: begin
            sum_s = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
            y     = sum_s[WIDTH-1:0];
            cout  = sum_s[WIDTH];
            ovf   = ~a[WIDTH-1] & y[WIDTH-1];
         end
         OP_PASS: y = a;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOT:  y = ~a;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/alu_acc_unit.sv
// Accumulator execute unit: accepts a command, runs it through the ALU core
// against the accumulator, and returns the registered result and NZCV flags.
module alu_acc_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_load,
   input  logic             cmd_chain,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [3:0]       res_flags
);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             load_q, load_d;
   logic             chain_q, chain_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [3:0]       flags_q, flags_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             res_valid_q, res_valid_d;

   logic [WIDTH-1:0] alu_y_s;
   logic             alu_cout_s;
   logic             alu_ovf_s;
   logic             alu_cin_s;
   logic             arith_s;
   logic             chain_eff_s;
   logic             no_cv_s;
   logic             zero_s;

   // Carry-in: chained ops take stored C; unchained SUB needs +1 for two's complement
   always_comb begin
      arith_s     = (op_q == OP_ADD) || (op_q == OP_SUB);
      chain_eff_s = chain_q & arith_s;
      no_cv_s     = op_q[2] | (op_q == OP_PASS);
      if (chain_eff_s) begin
         alu_cin_s = flags_q[FLG_C];
      end else begin
         alu_cin_s = (op_q == OP_SUB);
      end
   end

   alu8_core #(.WIDTH(WIDTH)) u_core (
      .a    (acc_q),
      .b    (data_q),
      .op   (op_q),
      .cin  (alu_cin_s),
      .y    (alu_y_s),
      .cout (alu_cout_s),
      .ovf  (alu_ovf_s)
   );

   assign zero_s = (alu_y_s == {WIDTH{1'b0}});

   // FSM, command capture and accumulator/flag update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      load_d  = load_q;
      chain_d = chain_q;
      data_d  = data_q;
      acc_d   = acc_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = EXEC;
               op_d    = cmd_op;
               load_d  = cmd_load;
               chain_d = cmd_chain;
               data_d  = cmd_data;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            state_d = RESP;
            if (load_q) begin
               // Flags deliberately kept so C and Z carry across a byte load
               acc_d = data_q;
            end else begin
               acc_d          = alu_y_s;
               flags_d[FLG_N] = alu_y_s[WIDTH-1];
               flags_d[FLG_Z] = chain_eff_s ? (flags_q[FLG_Z] & zero_s) : zero_s;
               flags_d[FLG_C] = no_cv_s ? 1'b0 : alu_cout_s;
               flags_d[FLG_V] = no_cv_s ? 1'b0 : alu_ovf_s;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
      res_valid_d = (state_d == RESP);
   end

   // State and datapath registers; reset aborts any command in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 3'd0;
         load_q      <= 1'b0;
         chain_q     <= 1'b0;
         data_q      <= {WIDTH{1'b0}};
         acc_q       <= {WIDTH{1'b0}};
         flags_q     <= 4'd0;
         cmd_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         load_q      <= load_d;
         chain_q     <= chain_d;
         data_q      <= data_d;
         acc_q       <= acc_d;
         flags_q     <= flags_d;
         cmd_ready_q <= cmd_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = acc_q;
   assign res_flags = flags_q;

endmodule

// File: tb/tb_alu_acc_unit.sv
// Scoreboard bench for alu_acc_unit: directed commands push hand-computed
// results into a queue; a monitor pops and compares on each result handshake.
module tb_alu_acc_unit;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_load;
   logic       cmd_chain;
   logic [7:0] cmd_data;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_flags;

   logic [11:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, INC = 3'd2, PAS = 3'd3;
   localparam logic [2:0] AND = 3'd4, ORR = 3'd5, XOR = 3'd6, NOT = 3'd7;

   alu_acc_unit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_load  (cmd_load),
      .cmd_chain (cmd_chain),
      .cmd_data  (cmd_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_flags (res_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: compare every consumed result against the scoreboard head
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {20'd0, res_data, res_flags}, 32'hFFFF_FFFF);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check("res_data", {24'd0, res_data}, {24'd0, e[11:4]});
            check("res_flags", {28'd0, res_flags}, {28'd0, e[3:0]});
         end
      end
   end

   task automatic issue(input logic ld, input logic ch, input logic [2:0] op,
                        input logic [7:0] d, input logic [7:0] ed, input logic [3:0] ef);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_load = ld; cmd_chain = ch; cmd_op = op; cmd_data = d;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_timeout", 32'd0, 32'd1);
      end else begin
         exp_q.push_back({ed, ef});
         @(posedge clk);
      end
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   typedef struct {
      logic       ld;
      logic       ch;
      logic [2:0] op;
      logic [7:0] d;
      logic [7:0] ed;
      logic [3:0] ef;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_load = 1'b0;
      cmd_chain = 1'b0; cmd_data = 8'h00; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_acc", {24'd0, res_data}, 32'd0);

      // LOAD 0x55 then reset during EXEC: nothing must come back
      @(negedge clk);
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_chain = 1'b0; cmd_op = ADD; cmd_data = 8'h55;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midop_acc", {24'd0, res_data}, 32'd0);
      check("midop_flags", {28'd0, res_flags}, 32'd0);
      check("midop_res_valid", {31'd0, res_valid}, 32'd0);
      check("midop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("midop_no_late_valid", {31'd0, res_valid}, 32'd0);

      //           ld    ch    op   data   exp   flags(NZCV)
      vecs = '{
         '{1'b1, 1'b0, ADD, 8'h7F, 8'h7F, 4'b0000},
         '{1'b0, 1'b0, ADD, 8'h01, 8'h80, 4'b1001},
         '{1'b1, 1'b0, ADD, 8'h7F, 8'h7F, 4'b1001},
         '{1'b0, 1'b0, INC, 8'h00, 8'h80, 4'b1001},
         '{1'b1, 1'b0, ADD, 8'h00, 8'h00, 4'b1001},
         '{1'b0, 1'b0, SUB, 8'h01, 8'hFF, 4'b1000},
         '{1'b1, 1'b0, ADD, 8'h05, 8'h05, 4'b1000},
         '{1'b0, 1'b0, SUB, 8'h05, 8'h00, 4'b0110},
         '{1'b1, 1'b0, ADD, 8'hFF, 8'hFF, 4'b0110},
         '{1'b0, 1'b0, ADD, 8'h01, 8'h00, 4'b0110},
         '{1'b1, 1'b0, ADD, 8'h01, 8'h01, 4'b0110},
         '{1'b0, 1'b1, ADD, 8'h00, 8'h02, 4'b0000},
         '{1'b1, 1'b0, ADD, 8'hFF, 8'hFF, 4'b0000},
         '{1'b0, 1'b0, ADD, 8'h01, 8'h00, 4'b0110},
         '{1'b1, 1'b0, ADD, 8'h00, 8'h00, 4'b0110},
         '{1'b0, 1'b1, ADD, 8'hFF, 8'h00, 4'b0110},
         '{1'b1, 1'b0, ADD, 8'hF0, 8'hF0, 4'b0110},
         '{1'b0, 1'b0, XOR, 8'hFF, 8'h0F, 4'b0000},
         '{1'b0, 1'b0, NOT, 8'h00, 8'hF0, 4'b1000},
         '{1'b0, 1'b1, PAS, 8'h00, 8'hF0, 4'b1000},
         '{1'b0, 1'b0, AND, 8'h3C, 8'h30, 4'b0000},
         '{1'b0, 1'b0, ORR, 8'h0F, 8'h3F, 4'b0000},
         '{1'b1, 1'b0, ADD, 8'hFF, 8'hFF, 4'b0000},
         '{1'b0, 1'b0, INC, 8'h00, 8'h00, 4'b0110},
         '{1'b1, 1'b0, ADD, 8'h10, 8'h10, 4'b0110},
         '{1'b0, 1'b1, SUB, 8'h01, 8'h0F, 4'b0010},
         '{1'b1, 1'b0, ADD, 8'h00, 8'h00, 4'b0010},
         '{1'b0, 1'b0, SUB, 8'h01, 8'hFF, 4'b1000},
         '{1'b1, 1'b0, ADD, 8'h05, 8'h05, 4'b1000},
         '{1'b0, 1'b1, SUB, 8'h01, 8'h03, 4'b0010},
         '{1'b1, 1'b0, ADD, 8'h80, 8'h80, 4'b0010},
         '{1'b0, 1'b0, ADD, 8'h80, 8'h00, 4'b0111}
      };
      foreach (vecs[i])
         issue(vecs[i].ld, vecs[i].ch, vecs[i].op, vecs[i].d, vecs[i].ed, vecs[i].ef);
      drain();

      // Backpressure: hold the result while a second command waits
      res_ready = 1'b0;
      issue(1'b1, 1'b0, ADD, 8'h3C, 8'h3C, 4'b0111);
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_chain = 1'b0; cmd_op = ADD; cmd_data = 8'h01;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_res_valid", {31'd0, res_valid}, 32'd1);
         check("bp_res_data", {24'd0, res_data}, 32'h3C);
         check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      exp_q.push_back({8'h3D, 4'b0000});
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      check("bp_accepted", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_acc_unit.md
# alu_acc_unit

Sequential 8-bit accumulator execute unit that sits on the consumer side of the team's combinational 8-bit ALU. It accepts operation commands over a valid/ready handshake, applies them to an internal accumulator through the ALU, and registers the result and the NZCV flags. It returns each result over a second valid/ready handshake. Carry chaining supports multi-byte add/subtract and multi-byte zero detection.

## Interface
Parameters:
- WIDTH, 8, datapath width; the unit is verified only at 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command; high only in IDLE.
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 INC, 011 PASS, 100 AND, 101 OR, 110 XOR, 111 NOT.
- cmd_load  in  1  1 = load cmd_data into the accumulator; cmd_op is ignored.
- cmd_chain  in  1  1 = use the stored C flag as carry-in (ADD/SUB only).
- cmd_data  in  WIDTH  B operand, or the load value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  accumulator value.
- res_flags  out  4  {N, Z, C, V}.

## Operation
- A operand = accumulator; B = cmd_data. The command is captured into registers on handshake (cmd_valid & cmd_ready).
- FSM states:
  - IDLE: cmd_ready=1. On handshake, go to EXEC.
  - EXEC: the ALU computes from captured operands; acc and flags update at the end of this cycle. Always go to RESP.
  - RESP: res_valid=1. On res_ready, go to IDLE; otherwise stay.
- Results per operation:
  - ADD: {C,acc} = A+B+(chain?C:0).
  - SUB: {C,acc} = A+~B+(chain?C:1). C = no-borrow, i.e. 1 when A>=B for unchained SUB.
  - INC: A+1; C is the carry out.
  - PASS: acc = A.
  - AND/OR/XOR: bitwise A op B.
  - NOT: acc = ~A.
- Overflow V:
  - ADD: operands have equal sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
  - INC: V=1 only when A=0x7F.
- PASS and all logic ops (op[2]=1) force C=0 and V=0.
- N = acc[7].
- Z = (acc==0), except chained ADD/SUB, where Z = Z_prev & (acc==0).
- cmd_chain is ignored for ops other than ADD/SUB.
- LOAD: acc = cmd_data; all four flags are unchanged, so C and Z survive for chaining. LOAD passes through EXEC/RESP and returns the new acc.
- Commands offered outside IDLE are not accepted; cmd_valid is simply held by the producer.

## Timing
- Handshake in cycle T → EXEC in T+1 → res_valid=1 from T+2.
- If res_ready=1 at T+2, the unit is in IDLE at T+3 (cmd_ready=1). Peak throughput: one command per 3 cycles.
- res_data and res_flags are registered and stable for the whole time res_valid is high. They keep the last value after the result is consumed.
- Reset values: state IDLE, acc=0x00, flags=0000, res_valid=0, cmd_ready=1, captured operands 0.
- Reset asserted in any state (including EXEC or RESP) aborts the operation immediately. No result is produced for the aborted command.
- Wrap-around: ADD 0xFF+0x01 → 0x00, C=1, Z=1. INC 0xFF → 0x00, C=1, V=0.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_NOT);
  - flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0);
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- Sub-module alu8_core: purely combinational. Inputs: a, b, op, cin. Outputs: y, cout, ovf. Flag masking and Z chaining are done in alu_acc_unit, not in the core.
- Top: FSM, command capture registers, acc and flag registers, output drive.

## Test plan
- Reset mid-op: LOAD 0x55, assert rst during EXEC → acc=0x00, flags=0000, res_valid=0, cmd_ready=1. No result appears after release.
- Signed overflow: LOAD 0x7F, ADD 0x01 → res 0x80, N=1 Z=0 C=0 V=1. Then INC with acc=0x7F → 0x80, V=1.
- Subtract: LOAD 0x00, SUB 0x01 → 0xFF, N=1 Z=0 C=0 V=0. Then LOAD 0x05, SUB 0x05 → 0x00, Z=1 C=1 V=0.
- 16-bit chain 0x01FF+0x0001: LOAD 0xFF, ADD 0x01 → 0x00, C=1 Z=1. LOAD 0x01, ADD chain 0x00 → 0x02, C=0 Z=0. Repeat with 0x00FF+0xFF01 → high byte 0x00, chained Z=1.
- Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 → res_valid stays 1, res_data stable, cmd_ready=0, no second command accepted. Release → next handshake one cycle after IDLE is reached.
- Logic clears arithmetic flags: after a result with C=1, LOAD 0xF0, XOR 0xFF → 0x0F, N=0 Z=0 C=0 V=0. Then NOT → 0xF0, N=1.
